hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational D-stage hazard detector of the MIPS pipeline.
- Owns a shift-register scoreboard of in-flight register writes (E, M, W, ... up to DEPTH stages), with per-entry Tnew countdown.
- Owns the mul/div busy countdown and tracks pending mtc0-to-EPC writes.
- Sits beside the D stage and drives the single pipeline stall; D/E pipeline registers consume it.

Parameters:
- ADDR_W, 5, GPR address width; address 0 is never a hazard.
- TIME_W, 2, width of Tuse/Tnew fields.
- DEPTH, 3, tracked stages after D (index 0 = E); legal range 2..6.
- MUL_CYCLES, 5, busy cycles loaded for mult/multu.
- DIV_CYCLES, 10, busy cycles loaded for div/divu; must be ≥ MUL_CYCLES.
- EPC_ADDR, 14, CP0 register number of EPC.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- D_valid  in  1  D holds a real instruction.
- D_Rs_Addr  in  ADDR_W  rs source address.
- D_Rs_Tuse  in  TIME_W  cycles until rs is needed.
- D_Rt_Addr  in  ADDR_W  rt source address.
- D_Rt_Tuse  in  TIME_W  cycles until rt is needed.
- D_Reg_WA  in  ADDR_W  destination GPR (0 = none).
- D_Tnew  in  TIME_W  Tnew the instruction will have in E.
- D_EPC_WE  in  1  instruction is mtc0 to EPC_ADDR.
- D_eret  in  1  instruction is eret.
- D_MD_Start  in  1  mult/multu/div/divu.
- D_MD_IsDiv  in  1  start is a divide.
- D_MD_Use  in  1  mfhi/mflo/mthi/mtlo.
- flush  in  1  exception/eret redirect; kills all in-flight entries.
- stall  out  1  hold PC/F/D, bubble into E.
- stall_cause  out  4  {eret, md, rt, rs}; one-hot-or-more, valid whenever stall=1.
- md_busy  out  1  mul/div unit busy.

Behaviour:
- Entry = {v, wa, tnew, epc}. Scoreboard is entry[0..DEPTH-1].
- stall_rs: D_valid and D_Rs_Addr≠0 and any entry with v, wa==D_Rs_Addr, D_Rs_Tuse<tnew. stall_rt is the same check on rt.
- stall_md: D_valid and (D_MD_Start or D_MD_Use) and md_busy.
- stall_eret: D_valid and D_eret and any entry with v and epc.
- stall is the OR of the four causes and is purely combinational from state and D inputs; it never depends on flush.
- Every clock edge, for i≥1: entry[i] ← entry[i-1] with tnew decremented, saturating at 0. entry[DEPTH-1] falls off.
- entry[0] takes the D instruction when D_valid, !stall and !flush, with v=(D_Reg_WA≠0 or D_EPC_WE); otherwise entry[0] takes a bubble (all zero).
- flush: every entry cleared on that edge; this takes priority over shift and insert.
- md counter, width clog2(DIV_CYCLES+1):
  - Loads DIV_CYCLES or MUL_CYCLES when D_valid, D_MD_Start, !stall and !flush.
  - Otherwise decrements to 0 and holds there.
  - md_busy = counter≠0, registered state only; the start cycle itself is not busy.
  - flush does not abort an issued operation.
- The same address in several entries is legal; any matching entry can stall.
- Reset: all entries zero, counter 0, so stall=0, stall_cause=0 and md_busy=0 while reset_n=0. Reset asserted mid-operation clears everything immediately.

Optional Feature:
- HAZARD_STATS_EN defined: adds outputs stall_cycles (32) and md_stall_cycles (32).
  - stall_cycles counts cycles with stall=1; md_stall_cycles counts cycles with stall_cause[2]=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- lw $3 (Tnew=2) then immediately addu using rs=$3 (Tuse=1) -> stall=1, cause=0001 for 1 cycle; then stall=0 once that entry's tnew=1.
- Write to $0 with Tnew=2 followed by rs=$0, Tuse=0 -> stall stays 0.
- div issued at t, then mflo at t+1 -> md_busy=1 for t+1..t+10; stall=1 with cause=0100 until counter reaches 0; mflo issues at t+11.
- mtc0 EPC followed by eret -> stall=1 with cause=1000 while the mtc0 entry is in stages 0..DEPTH-1 (3 cycles at DEPTH=3), then the eret issues.
- lw $5 in E with flush=1, then addu using $5 next cycle -> scoreboard empty, stall=0.
- reset_n pulled low mid-div (counter=6) -> md_busy=0 and stall=0 immediately; after release, mult loads the counter with 5.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard with shift-register writer tracking, mul/div busy countdown and EPC guard; optional HAZARD_STATS_EN stall counters.
// Latency: stall is combinational from state and D inputs; no backpressure input, stall holds PC/F/D and bubbles E.
module hazard_scoreboard #(
  parameter int ADDR_W     = 5,
  parameter int TIME_W     = 2,
  parameter int DEPTH      = 3,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int EPC_ADDR   = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              D_valid,
  input  logic [ADDR_W-1:0] D_Rs_Addr,
  input  logic [TIME_W-1:0] D_Rs_Tuse,
  input  logic [ADDR_W-1:0] D_Rt_Addr,
  input  logic [TIME_W-1:0] D_Rt_Tuse,
  input  logic [ADDR_W-1:0] D_Reg_WA,
  input  logic [TIME_W-1:0] D_Tnew,
  input  logic              D_EPC_WE,
  input  logic              D_eret,
  input  logic              D_MD_Start,
  input  logic              D_MD_IsDiv,
  input  logic              D_MD_Use,
  input  logic              flush,
  output logic              stall,
  output logic [3:0]        stall_cause,
  output logic              md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       md_stall_cycles
`endif
);

  localparam int MD_W = $clog2(DIV_CYCLES + 1);

  if (DEPTH < 2 || DEPTH > 6) begin : g_bad_depth
    $error("hazard_scoreboard: DEPTH must be 2..6");
  end
  if (DIV_CYCLES < MUL_CYCLES) begin : g_bad_md
    $error("hazard_scoreboard: DIV_CYCLES must be >= MUL_CYCLES");
  end
  if (EPC_ADDR < 0 || EPC_ADDR > 31) begin : g_bad_epc
    $error("hazard_scoreboard: EPC_ADDR is not a CP0 register number");
  end

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] wa;
    logic [TIME_W-1:0] tnew;
    logic              epc;
  } entry_t;

  entry_t          sb_q [DEPTH];
  entry_t          ins_entry;
  logic [MD_W-1:0] md_cnt_q;
  logic            hit_rs, hit_rt, hit_epc;
  logic            stall_rs, stall_rt, stall_md, stall_eret;
  logic            issue;

  function automatic entry_t age(input entry_t e);
    entry_t r;
    r = e;
    r.tnew = (e.tnew == '0) ? '0 : e.tnew - TIME_W'(1);
    return r;
  endfunction

  always_comb begin
    hit_rs  = 1'b0;
    hit_rt  = 1'b0;
    hit_epc = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_q[i].v && sb_q[i].wa == D_Rs_Addr && D_Rs_Tuse < sb_q[i].tnew) hit_rs = 1'b1;
      if (sb_q[i].v && sb_q[i].wa == D_Rt_Addr && D_Rt_Tuse < sb_q[i].tnew) hit_rt = 1'b1;
      if (sb_q[i].v && sb_q[i].epc) hit_epc = 1'b1;
    end
  end

  assign md_busy     = (md_cnt_q != '0);
  assign stall_rs    = D_valid && (D_Rs_Addr != '0) && hit_rs;
  assign stall_rt    = D_valid && (D_Rt_Addr != '0) && hit_rt;
  assign stall_md    = D_valid && (D_MD_Start || D_MD_Use) && md_busy;
  assign stall_eret  = D_valid && D_eret && hit_epc;
  assign stall_cause = {stall_eret, stall_md, stall_rt, stall_rs};
  assign stall       = |stall_cause;
  assign issue       = D_valid && !stall && !flush;

  always_comb begin
    ins_entry      = '0;
    ins_entry.v    = (D_Reg_WA != '0) || D_EPC_WE;
    ins_entry.wa   = D_Reg_WA;
    ins_entry.tnew = D_Tnew;
    ins_entry.epc  = D_EPC_WE;
  end

  // Flush wipes the scoreboard but leaves an issued mul/div running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= '0;
      md_cnt_q <= '0;
    end else begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) sb_q[i] <= '0;
      end else begin
        sb_q[0] <= issue ? ins_entry : '0;
        for (int i = 1; i < DEPTH; i++) sb_q[i] <= age(sb_q[i-1]);
      end
      if (issue && D_MD_Start)
        md_cnt_q <= D_MD_IsDiv ? MD_W'(DIV_CYCLES) : MD_W'(MUL_CYCLES);
      else if (md_busy)
        md_cnt_q <= md_cnt_q - MD_W'(1);
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles    <= '0;
      md_stall_cycles <= '0;
    end else begin
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (stall_md && md_stall_cycles != '1) md_stall_cycles <= md_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: timestamp-based reference model checked every cycle plus literal expectations.
module tb_hazard_scoreboard;
  localparam int ADDR_W = 5, TIME_W = 2, DEPTH = 3;
  localparam int MUL_CYCLES = 5, DIV_CYCLES = 10, EPC_ADDR = 14;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic D_valid, D_EPC_WE, D_eret, D_MD_Start, D_MD_IsDiv, D_MD_Use, flush;
  logic [ADDR_W-1:0] D_Rs_Addr, D_Rt_Addr, D_Reg_WA;
  logic [TIME_W-1:0] D_Rs_Tuse, D_Rt_Tuse, D_Tnew;
  logic stall, md_busy;
  logic [3:0] stall_cause;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, md_stall_cycles;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  hazard_scoreboard #(
    .ADDR_W(ADDR_W), .TIME_W(TIME_W), .DEPTH(DEPTH),
    .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES), .EPC_ADDR(EPC_ADDR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .D_valid(D_valid),
    .D_Rs_Addr(D_Rs_Addr), .D_Rs_Tuse(D_Rs_Tuse),
    .D_Rt_Addr(D_Rt_Addr), .D_Rt_Tuse(D_Rt_Tuse),
    .D_Reg_WA(D_Reg_WA), .D_Tnew(D_Tnew), .D_EPC_WE(D_EPC_WE), .D_eret(D_eret),
    .D_MD_Start(D_MD_Start), .D_MD_IsDiv(D_MD_IsDiv), .D_MD_Use(D_MD_Use),
    .flush(flush), .stall(stall), .stall_cause(stall_cause), .md_busy(md_busy)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .md_stall_cycles(md_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [5:0] got, input logic [5:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: {stall,cause,busy} got %b want %b at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: each issued writer is stamped with the cycle it sits in E;
  // its stage and remaining Tnew follow from elapsed cycles.
  typedef struct { int stamp; int wa; int tnew; bit epc; } rec_t;
  rec_t q[$];
  int cyc = 0;
  int md_start = 0;
  int md_len = 0;
  logic [5:0] exp_v = '0;

  always @(negedge clk) begin
    bit rs_h, rt_h, e_h, md_h, busy;
    int s, tn;
    rs_h = 0; rt_h = 0; e_h = 0;
    foreach (q[i]) begin
      s = cyc - q[i].stamp;
      if (s < DEPTH) begin
        tn = (q[i].tnew > s) ? q[i].tnew - s : 0;
        if (D_Rs_Addr != 0 && q[i].wa == int'(D_Rs_Addr) && int'(D_Rs_Tuse) < tn) rs_h = 1;
        if (D_Rt_Addr != 0 && q[i].wa == int'(D_Rt_Addr) && int'(D_Rt_Tuse) < tn) rt_h = 1;
        if (q[i].epc) e_h = 1;
      end
    end
    busy = (cyc >= md_start) && (cyc < md_start + md_len);
    md_h = D_valid && (D_MD_Start || D_MD_Use) && busy;
    rs_h = rs_h && D_valid;
    rt_h = rt_h && D_valid;
    e_h  = e_h && D_valid && D_eret;
    exp_v = {(rs_h | rt_h | md_h | e_h), e_h, md_h, rt_h, rs_h, busy};
    chk("model", {stall, stall_cause, md_busy}, exp_v);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      md_len = 0;
    end else begin
      if (flush) q.delete();
      else if (D_valid && !exp_v[5]) begin
        if (D_Reg_WA != 0 || D_EPC_WE) q.push_back('{cyc + 1, int'(D_Reg_WA), int'(D_Tnew), D_EPC_WE});
        if (D_MD_Start) begin
          md_start = cyc + 1;
          md_len = D_MD_IsDiv ? DIV_CYCLES : MUL_CYCLES;
        end
      end
      cyc++;
      while (q.size() > 0 && cyc - q[0].stamp >= DEPTH) void'(q.pop_front());
    end
  end

  task automatic idle();
    D_valid = 0; D_Rs_Addr = '0; D_Rs_Tuse = '0; D_Rt_Addr = '0; D_Rt_Tuse = '0;
    D_Reg_WA = '0; D_Tnew = '0; D_EPC_WE = 0; D_eret = 0;
    D_MD_Start = 0; D_MD_IsDiv = 0; D_MD_Use = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) tick();
  endtask

  task automatic alu(input int rs, input int rs_t, input int rt, input int rt_t, input int wa, input int tn);
    idle();
    D_valid = 1;
    D_Rs_Addr = ADDR_W'(rs); D_Rs_Tuse = TIME_W'(rs_t);
    D_Rt_Addr = ADDR_W'(rt); D_Rt_Tuse = TIME_W'(rt_t);
    D_Reg_WA = ADDR_W'(wa); D_Tnew = TIME_W'(tn);
  endtask

  task automatic lit(input string name, input logic s, input logic [3:0] c, input logic b);
    #1;
    chk(name, {stall, stall_cause, md_busy}, {s, c, b});
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    idle();
    #2;
    lit("reset_idle", 0, 4'b0000, 0);
    tick(); tick();
    reset_n = 1;
    tick();

    // lw $3 (Tnew 2) then addu rs=$3 (Tuse 1)
    alu(1, 1, 0, 0, 3, 2); tick();
    alu(3, 1, 4, 1, 6, 1);
    lit("raw_rs_stall", 1, 4'b0001, 0); tick();
    lit("raw_rs_clear", 0, 4'b0000, 0); tick();
    drain(3);

    // both sources on one producer, different Tuse
    alu(1, 1, 0, 0, 3, 2); tick();
    alu(3, 1, 3, 0, 7, 1);
    lit("raw_rs_rt", 1, 4'b0011, 0); tick();
    lit("raw_rt_only", 1, 4'b0010, 0); tick();
    lit("raw_both_clear", 0, 4'b0000, 0); tick();
    drain(3);

    // Tnew 3 producer stays visible through the last stage, then falls off
    alu(1, 1, 0, 0, 7, 3); tick();
    alu(0, 0, 7, 0, 9, 1);
    for (int k = 0; k < DEPTH; k++) begin
      lit("raw_rt_last_stage", 1, 4'b0010, 0); tick();
    end
    lit("raw_rt_fall_off", 0, 4'b0000, 0); tick();
    drain(3);

    // $0 destination never hazards
    alu(1, 1, 0, 0, 0, 2); tick();
    alu(0, 0, 0, 0, 5, 1);
    lit("zero_reg", 0, 4'b0000, 0); tick();
    drain(3);

    // div then mflo
    idle(); D_valid = 1; D_MD_Start = 1; D_MD_IsDiv = 1;
    lit("div_start_not_busy", 0, 4'b0000, 0); tick();
    idle(); D_valid = 1; D_MD_Use = 1; D_Reg_WA = 5'd8; D_Tnew = 2'd1;
    for (int k = 0; k < DIV_CYCLES; k++) begin
      lit("mflo_md_stall", 1, 4'b0100, 1); tick();
    end
    lit("mflo_issue", 0, 4'b0000, 0); tick();
    drain(2);

    // mtc0 EPC then eret
    idle(); D_valid = 1; D_EPC_WE = 1; tick();
    idle(); D_valid = 1; D_eret = 1;
    for (int k = 0; k < DEPTH; k++) begin
      lit("eret_epc_stall", 1, 4'b1000, 0); tick();
    end
    lit("eret_issue", 0, 4'b0000, 0); tick();
    drain(3);

    // flush clears lw $5 in E
    alu(1, 1, 0, 0, 5, 2); tick();
    idle(); flush = 1; tick();
    alu(5, 0, 0, 0, 6, 1);
    lit("post_flush_empty", 0, 4'b0000, 0); tick();
    drain(3);

    // stall ignores flush; flush still empties the scoreboard
    alu(1, 1, 0, 0, 9, 2); tick();
    alu(9, 0, 0, 0, 2, 1); flush = 1;
    lit("stall_indep_flush", 1, 4'b0001, 0); tick();
    flush = 0;
    lit("flushed_no_stall", 0, 4'b0000, 0); tick();
    drain(3);

    // two in-flight writers of $10
    alu(1, 1, 0, 0, 10, 2); tick();
    alu(0, 0, 0, 0, 10, 1); tick();
    alu(10, 0, 0, 0, 11, 1);
    lit("dup_addr_stall", 1, 4'b0001, 0); tick();
    lit("dup_addr_clear", 0, 4'b0000, 0); tick();
    drain(3);

    // reset mid-div, then mult loads 5
    idle(); D_valid = 1; D_MD_Start = 1; D_MD_IsDiv = 1; tick();
    idle(); D_valid = 1; D_MD_Use = 1; D_Reg_WA = 5'd8; D_Tnew = 2'd1;
    repeat (4) tick();
    lit("pre_reset_busy", 1, 4'b0100, 1);
    reset_n = 0;
    lit("reset_mid_div", 0, 4'b0000, 0);
    tick(); tick();
    reset_n = 1;
    idle(); D_valid = 1; D_MD_Start = 1;
    lit("mult_start", 0, 4'b0000, 0); tick();
    idle();
    for (int k = 0; k < MUL_CYCLES; k++) begin
      lit("mult_busy", 0, 4'b0000, 1); tick();
    end
    lit("mult_done", 0, 4'b0000, 0); tick();
    drain(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
